// File: rtl/lsu_pkg.sv
// Shared types for the load/store stage.
//   mem_op_e  : memory operation carried from EXU.
//   exu_lsu_t : EXU -> LSU payload.
//   lsu_wb_t  : LSU -> write-back payload.
//   is_store  : helper that classifies store operations.
package lsu_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LH       = 4'd2,
    LW       = 4'd3,
    LBU      = 4'd4,
    LHU      = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_e;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    mem_op_e     mem_op;
    logic        reg_wen;
    logic [31:0] pc_target;
  } exu_lsu_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] wb_data;
    logic        reg_wen;
    logic [31:0] pc_target;
  } lsu_wb_t;

  function automatic logic is_store(mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Generic valid/ready pipeline-stage handshake carrying a typed payload.
//   valid   : producer has a payload.
//   ready   : consumer can take it; transfer when both are high.
//   payload : data of type payload_t.
// master = producer side, slave = consumer side.
interface stage_if #(
  parameter type payload_t = logic
) ();
  logic     valid;
  logic     ready;
  payload_t payload;

  modport master (output valid, output payload, input ready);
  modport slave  (input valid, input payload, output ready);
endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane logic for the load/store unit.
//   mem_op     : operation being aligned.
//   lane       : addr[1:0] of the access.
//   store_data : raw store value from EXU.
//   rdata      : raw word returned by the data bus.
//   wdata      : store data replicated into every candidate lane.
//   wstrb      : byte enables (zero for loads and non-memory ops).
//   misaligned : halfword on odd address or word not on 4-byte boundary.
//   load_data  : extracted and sign/zero extended load result.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_op_e     mem_op,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [7:0]  rbytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbytes[gi] = rdata[8*gi +: 8];
  end

  assign byte_sel = rbytes[lane];
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  // Replicating the data means the strobes alone select the lanes the
  // memory actually writes.
  always_comb begin
    wdata      = '0;
    wstrb      = '0;
    misaligned = 1'b0;
    case (mem_op)
      SB: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << lane;
      end
      SH: begin
        wdata      = {2{store_data[15:0]}};
        wstrb      = 4'b0011 << lane;
        misaligned = lane[0];
      end
      SW: begin
        wdata      = store_data;
        wstrb      = 4'hF;
        misaligned = (lane != 2'b00);
      end
      LH, LHU: misaligned = lane[0];
      LW:      misaligned = (lane != 2'b00);
      default: ;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (mem_op)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data = {24'd0, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data = {16'd0, half_sel};
      LW:      load_data = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store stage between EXU and write-back.
//   clk, rst_n       : clock, asynchronous active-low reset.
//   exu_in           : instruction from EXU (stage_if slave, exu_lsu_t).
//   lsu_out          : result to write-back (stage_if master, lsu_wb_t).
//   dmem_req_*       : single-beat data-bus request (word-aligned address).
//   dmem_resp_*      : data-bus response (data + error).
//   lsu_err          : one-cycle pulse on misalign, bus error or timeout.
// One instruction in flight; every output is decoded from state/registers.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  stage_if.slave      exu_in,
  stage_if.master     lsu_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_req_addr,
  output logic        dmem_req_wen,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_wstrb,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_rdata,
  input  logic        dmem_resp_err,
  output logic        lsu_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  // Last counter value before the response is declared lost.
  localparam logic [15:0] TIMEOUT_LAST = 16'(RESP_TIMEOUT - 1);

  logic [1:0]  state_reg;
  exu_lsu_t    op_reg;
  lsu_wb_t     wb_reg;
  logic        err_reg;
  logic [15:0] cnt_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;

  // In S_IDLE the aligner looks at the incoming instruction (misalign check
  // and lane data captured at fire); afterwards it looks at the latched one.
  exu_lsu_t    cur_op;
  logic [31:0] align_wdata;
  logic [3:0]  align_wstrb;
  logic        align_misaligned;
  logic [31:0] align_load_data;
  lsu_wb_t     squash_wb;

  assign cur_op = (state_reg == S_IDLE) ? exu_in.payload : op_reg;

  lsu_align u_align (
    .mem_op     (cur_op.mem_op),
    .lane       (cur_op.alu_result[1:0]),
    .store_data (cur_op.store_data),
    .rdata      (dmem_resp_rdata),
    .wdata      (align_wdata),
    .wstrb      (align_wstrb),
    .misaligned (align_misaligned),
    .load_data  (align_load_data)
  );

  // Result used for stores and for any faulted access: no register write.
  assign squash_wb = '{rd_addr: cur_op.rd_addr, wb_data: 32'd0,
                       reg_wen: 1'b0, pc_target: cur_op.pc_target};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      wb_reg    <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
    end else begin
      // lsu_err only ever lasts for the first cycle of S_OUT.
      err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (exu_in.valid) begin
            op_reg    <= exu_in.payload;
            wdata_reg <= align_wdata;
            wstrb_reg <= align_wstrb;
            cnt_reg   <= '0;
            if (cur_op.mem_op == MEM_NONE) begin
              wb_reg    <= '{rd_addr: cur_op.rd_addr, wb_data: cur_op.alu_result,
                             reg_wen: cur_op.reg_wen, pc_target: cur_op.pc_target};
              state_reg <= S_OUT;
            end else if (align_misaligned) begin
              wb_reg    <= squash_wb;
              err_reg   <= 1'b1;
              state_reg <= S_OUT;
            end else begin
              state_reg <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response in the same cycle as the timeout still wins.
          if (dmem_resp_valid) begin
            state_reg <= S_OUT;
            if (dmem_resp_err) begin
              wb_reg  <= squash_wb;
              err_reg <= 1'b1;
            end else if (is_store(op_reg.mem_op)) begin
              wb_reg <= squash_wb;
            end else begin
              wb_reg <= '{rd_addr: op_reg.rd_addr, wb_data: align_load_data,
                          reg_wen: op_reg.reg_wen, pc_target: op_reg.pc_target};
            end
          end else if (cnt_reg == TIMEOUT_LAST) begin
            wb_reg    <= squash_wb;
            err_reg   <= 1'b1;
            state_reg <= S_OUT;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        S_OUT: begin
          if (lsu_out.ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign exu_in.ready    = (state_reg == S_IDLE);
  assign lsu_out.valid   = (state_reg == S_OUT);
  assign lsu_out.payload = wb_reg;
  assign dmem_req_valid  = (state_reg == S_REQ);
  assign dmem_req_addr   = {op_reg.alu_result[31:2], 2'b00};
  assign dmem_req_wen    = is_store(op_reg.mem_op);
  assign dmem_req_wdata  = wdata_reg;
  assign dmem_req_wstrb  = wstrb_reg;
  assign lsu_err         = err_reg;

endmodule
